// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared source encodings and default ROB tag width for the CDB arbiter slice.
// Revision: 1.0
`default_nettype none

package cdb_arbiter_pkg;

    localparam int ROB_R = 4;

    typedef enum logic {
        SRC_RS  = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-producer handshakes (RS, LSB) and the broadcast CDB.
// Revision: 1.0
`default_nettype none

interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W = ROB_R
);
    logic             rs_valid;
    logic             rs_ready;
    logic [ROB_W-1:0] rs_rob_id;
    logic [31:0]      rs_value;
    logic             lsb_valid;
    logic             lsb_ready;
    logic [ROB_W-1:0] lsb_rob_id;
    logic [31:0]      lsb_value;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob_id;
    logic [31:0]      cdb_value;

    modport master (
        output rs_valid, rs_rob_id, rs_value,
        output lsb_valid, lsb_rob_id, lsb_value,
        input  rs_ready, lsb_ready,
        input  cdb_valid, cdb_rob_id, cdb_value
    );

    modport slave (
        input  rs_valid, rs_rob_id, rs_value,
        input  lsb_valid, lsb_rob_id, lsb_value,
        output rs_ready, lsb_ready,
        output cdb_valid, cdb_rob_id, cdb_value
    );

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small power-of-two skid FIFO with flush; head data is visible combinationally.
// Revision: 1.0
`default_nettype none

module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int W     = 36,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic          flush,
    input  wire logic [W-1:0]  push_data,
    output logic      [W-1:0]  head_data,
    output logic      [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the single CDB writeback port between RS and LSB with skid FIFOs.
// Optional macro CDB_AGE_PRIO_EN: ties go to the older ROB tag. Revision: 1.0
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_W      = ROB_R,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    input  wire logic             rdy_in,
    input  wire logic             rob_clear,
    input  wire logic [ROB_W-1:0] rob_head_id,
    cdb_arbiter_if.slave          bus
);

    localparam int W  = ROB_W + 32;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [CW-1:0]    rs_count, lsb_count;
    logic [W-1:0]     rs_head, lsb_head, rs_cand_data, lsb_cand_data, grant_data;
    logic             active, flush, rs_xfer, lsb_xfer, rs_cand, lsb_cand;
    logic             grant_any, rs_grant, lsb_grant;
    logic             rs_push, rs_pop, lsb_push, lsb_pop;
    src_e             last_grant, grant_src, tie_pick;
    logic             cdb_valid_reg;
    logic [ROB_W-1:0] cdb_rob_id_reg;
    logic [31:0]      cdb_value_reg;

    assign active   = rdy_in && !rob_clear;
    assign flush    = rdy_in && rob_clear;
    assign bus.rs_ready  = (rs_count  < FULL);
    assign bus.lsb_ready = (lsb_count < FULL);
    assign rs_xfer  = active && bus.rs_valid  && bus.rs_ready;
    assign lsb_xfer = active && bus.lsb_valid && bus.lsb_ready;

    // An empty FIFO lets a transferring input bypass straight to arbitration.
    assign rs_cand  = (active && rs_count  != '0) || rs_xfer;
    assign lsb_cand = (active && lsb_count != '0) || lsb_xfer;
    assign rs_cand_data  = (rs_count  != '0) ? rs_head  : {bus.rs_rob_id,  bus.rs_value};
    assign lsb_cand_data = (lsb_count != '0) ? lsb_head : {bus.lsb_rob_id, bus.lsb_value};

`ifdef CDB_AGE_PRIO_EN
    logic [ROB_W-1:0] rs_age, lsb_age;
    assign rs_age  = rs_cand_data[W-1:32]  - rob_head_id;
    assign lsb_age = lsb_cand_data[W-1:32] - rob_head_id;
`else
    logic unused_head;
    assign unused_head = ^rob_head_id;
`endif

    always_comb begin
        tie_pick = (last_grant == SRC_LSB) ? SRC_RS : SRC_LSB;
`ifdef CDB_AGE_PRIO_EN
        if (rs_age < lsb_age) begin
            tie_pick = SRC_RS;
        end else if (lsb_age < rs_age) begin
            tie_pick = SRC_LSB;
        end
`endif
        grant_any = rs_cand || lsb_cand;
        grant_src = SRC_RS;
        if (rs_cand && lsb_cand) begin
            grant_src = tie_pick;
        end else if (lsb_cand) begin
            grant_src = SRC_LSB;
        end
    end

    assign rs_grant   = grant_any && (grant_src == SRC_RS);
    assign lsb_grant  = grant_any && (grant_src == SRC_LSB);
    assign rs_pop     = rs_grant  && (rs_count  != '0);
    assign lsb_pop    = lsb_grant && (lsb_count != '0);
    assign rs_push    = rs_xfer   && !(rs_grant  && rs_count  == '0);
    assign lsb_push   = lsb_xfer  && !(lsb_grant && lsb_count == '0);
    assign grant_data = rs_grant ? rs_cand_data : lsb_cand_data;

    cdb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_rs_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .push(rs_push), .pop(rs_pop), .flush(flush),
        .push_data({bus.rs_rob_id, bus.rs_value}), .head_data(rs_head), .count(rs_count)
    );

    cdb_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk_in(clk_in), .rst_in(rst_in), .push(lsb_push), .pop(lsb_pop), .flush(flush),
        .push_data({bus.lsb_rob_id, bus.lsb_value}), .head_data(lsb_head), .count(lsb_count)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cdb_valid_reg  <= 1'b0;
            cdb_rob_id_reg <= '0;
            cdb_value_reg  <= '0;
            last_grant     <= SRC_LSB;
        end else if (rdy_in) begin
            cdb_valid_reg <= grant_any;
            if (grant_any) begin
                cdb_rob_id_reg <= grant_data[W-1:32];
                cdb_value_reg  <= grant_data[31:0];
                last_grant     <= grant_src;
            end
        end
    end

    assign bus.cdb_valid  = cdb_valid_reg;
    assign bus.cdb_rob_id = cdb_rob_id_reg;
    assign bus.cdb_value  = cdb_value_reg;

endmodule

`default_nettype wire
